// File: rtl/simon_pkg.sv
// Shared constants and game-state encodings for the Simon button front end and game FSM.
package simon_pkg;

    localparam int unsigned NUM_BTN_DEF  = 4;
    localparam int unsigned BTN_W_DEF    = $clog2(NUM_BTN_DEF);
    localparam int unsigned DEBOUNCE_DEF = 3;
    localparam int unsigned GAP_DEF      = 2;

    typedef enum logic [2:0] {
        S_INIT,
        S_SHOW,
        S_WAIT,
        S_CHECK,
        S_WIN,
        S_ERROR
    } game_state_t;

    // The integration top drives the arbiter's accept input from this.
    function automatic logic accept_state(input game_state_t s);
        return (s == S_WAIT) || (s == S_ERROR);
    endfunction

endpackage

// File: rtl/simon_debounce.sv
// Single-button 2-flop synchroniser plus debounce counter; rise flags the cycle
// in which the debounced level is about to go from 0 to 1.
module simon_debounce
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk_tick,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Level flips on the sample after the counter has recorded DEBOUNCE differing samples.
    assign rise = sync & ~level & (cnt == CW'(DEBOUNCE));

    always_ff @(posedge clk_tick or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/simon_btn_arbiter.sv
// Debounces NUM_BTN buttons and arbitrates press events round-robin onto the
// game FSM's one-shot btn_valid/btn_val channel, with pulse spacing and drop counting.
module simon_btn_arbiter
    import simon_pkg::*;
#(
    parameter int unsigned  NUM_BTN  = NUM_BTN_DEF,
    parameter int unsigned  DEBOUNCE = DEBOUNCE_DEF,
    parameter int unsigned  GAP      = GAP_DEF,
    localparam int unsigned BTN_W    = $clog2(NUM_BTN)
) (
    input  logic               clk_tick,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               accept,
    output logic               btn_valid,
    output logic [BTN_W-1:0]   btn_val,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               busy,
    output logic [7:0]         drop_cnt
);

    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] pending_next;
    logic [NUM_BTN-1:0] grant_mask;
    logic [BTN_W-1:0]   rr_ptr;
    logic [BTN_W-1:0]   rr_next;
    logic [BTN_W-1:0]   winner;
    logic [BTN_W-1:0]   cand;
    logic               found;
    logic               grant;
    logic [GW-1:0]      gap_cnt;
    logic [7:0]         ev_pop;
    logic [8:0]         drop_sum;
    int unsigned        idx;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        simon_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_db (
            .clk_tick(clk_tick),
            .reset   (reset),
            .raw     (btn_raw[i]),
            .level   (btn_level[i]),
            .rise    (rise[i])
        );
    end

    // First pending bit at or above rr_ptr, wrapping modulo NUM_BTN.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_BTN; k++) begin
            idx  = (32'(rr_ptr) + k) % NUM_BTN;
            cand = BTN_W'(idx);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        grant      = (gap_cnt == '0) && accept && found;
        grant_mask = grant ? (NUM_BTN'(1) << winner) : '0;
        rr_next    = (winner == BTN_W'(NUM_BTN - 1)) ? '0 : winner + BTN_W'(1);
        // OR-ing rise after the grant clear makes a fresh event win over its own grant.
        pending_next = accept ? ((pending & ~grant_mask) | rise) : '0;
    end

    always_comb begin
        ev_pop = '0;
        for (int unsigned k = 0; k < NUM_BTN; k++) begin
            ev_pop = ev_pop + 8'(rise[k]);
        end
        drop_sum = {1'b0, drop_cnt} + {1'b0, ev_pop};
    end

    always_ff @(posedge clk_tick or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            busy      <= 1'b0;
            btn_valid <= 1'b0;
            btn_val   <= '0;
            rr_ptr    <= '0;
            gap_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            pending   <= pending_next;
            busy      <= |pending_next;
            btn_valid <= grant;
            if (grant) begin
                btn_val <= winner;
                rr_ptr  <= rr_next;
                gap_cnt <= GW'(GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
            if (!accept) begin
                drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
        end
    end

endmodule
